// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the synchronous instruction ROM and fills the IF/ID register.
// Handles hazard stalls and branch/jump redirects that squash any fetch already in flight.
module instruction_fetch #(
   parameter int unsigned          ADDR_W    = 10,
   parameter int unsigned          DATA_W    = 32,
   parameter logic [31:0]          RESET_PC  = 32'h0000_0000,
   parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
   input  logic              clka,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] if_instr,
   output logic [31:0]       if_pc_plus4,
   output logic              if_valid,
   output logic [31:0]       pc
);

   localparam int unsigned PC_W = 32;
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_req_pc;
   logic              r_req_valid;
   logic [DATA_W-1:0] r_if_instr;
   logic [PC_W-1:0]   r_if_pc_plus4;
   logic              r_if_valid;

   logic [PC_W-1:0]   w_redirect_target;
   logic              w_unused_pc_lsb;

   // Targets are word aligned; the byte offset bits of the request are dropped.
   assign w_redirect_target = {redirect_pc[31:2], 2'b00};
   assign w_unused_pc_lsb   = ^redirect_pc[1:0];

   // ROM side is combinational so the ROM samples the address of the current cycle.
   assign rom_en   = ~reset & (~stall | redirect);
   assign rom_addr = r_pc[ADDR_W+1:2];
   assign pc       = r_pc;

   assign if_instr    = r_if_instr;
   assign if_pc_plus4 = r_if_pc_plus4;
   assign if_valid    = r_if_valid;

   // PC, in-flight request tag and IF/ID register; reset beats redirect beats stall.
   always_ff @(posedge clka) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= '0;
         r_req_valid   <= 1'b0;
         r_if_instr    <= NOP_INSTR;
         r_if_pc_plus4 <= '0;
         r_if_valid    <= 1'b0;
      end else if (redirect) begin
         r_pc          <= w_redirect_target;
         r_req_valid   <= 1'b0;
         r_if_instr    <= NOP_INSTR;
         r_if_valid    <= 1'b0;
      end else if (!stall) begin
         r_req_pc      <= r_pc;
         r_req_valid   <= 1'b1;
         r_pc          <= r_pc + PC_STEP;
         r_if_instr    <= r_req_valid ? rom_data : NOP_INSTR;
         r_if_valid    <= r_req_valid;
         r_if_pc_plus4 <= r_req_pc + PC_STEP;
      end
   end

endmodule
